controle_bomba_dosagem: RTL
===========================

# controle_bomba_dosagem

Parametrised pump dosing controller for the coffee machine, replacing the fixed two-dose pump timer. It drives the pump for an exact dose chosen from two parameter presets or a runtime custom value. It also supports pause/resume (e.g. low water or open lid) with a pause watchdog, abort, and a live remaining-time readout. It sits between the main control FSM (`liga_bomba`/`fim_bomba` handshake) and the pump driver output.

## Interface
- `TICK_CYCLES`, 500000: clock cycles per dose tick (10 ms at 50 MHz).
- `TICK_W`, 16: width of dose / remaining-tick values.
- `DOSE_PEQUENO`, 625: ticks for small dose (6.25 s).
- `DOSE_GRANDE`, 1250: ticks for large dose (12.5 s).
- `PAUSA_MAX_CYCLES`, 1500000000: maximum continuous cycles in pause before timeout (30 s).

Ports:
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `modo` in 2: 01 = pequeno, 10 = grande, 11 = custom, 00 = invalid. Sampled only at start.
- `dose_custom` in TICK_W: dose in ticks for modo 11. Sampled only at start.
- `liga_bomba` in 1: start request, level-sampled, accepted only in IDLE.
- `pausa` in 1: level; while high the pump is held off and timing frozen.
- `aborta` in 1: level; terminates an active dose.
- `bomba` out 1: pump enable.
- `ocupado` out 1: high in BOMBEANDO and PAUSADO.
- `fim_bomba` out 1: one-cycle pulse on successful dose completion.
- `erro` out 1: one-cycle pulse on rejected start or failed dose.
- `codigo_erro` out 2: 01 = invalid mode/zero dose, 10 = pause timeout, 11 = aborted. Holds until the next accepted start or error.
- `restante` out TICK_W: ticks of dose remaining.

## Operation
- Reset (`reset`=0 at an edge): state IDLE. All outputs 0, including `codigo_erro` and `restante`. Prescaler and pause counter are cleared. Reset overrides everything, mid-dose included.
- States: IDLE, BOMBEANDO, PAUSADO. All outputs are registered.
- **IDLE**, with `liga_bomba`=1 and `aborta`=0:
  - Dose is DOSE_PEQUENO, DOSE_GRANDE or `dose_custom` per `modo`.
  - If `modo`=00 or the selected dose is 0: pulse `erro`, set `codigo_erro`=01, stay IDLE.
  - Otherwise: load `restante`=dose, clear prescaler, clear `codigo_erro`, set `bomba`=1 and `ocupado`=1, go to BOMBEANDO.
- **BOMBEANDO**:
  - The prescaler counts 0..TICK_CYCLES-1 each cycle.
  - At count TICK_CYCLES-1 (tick), the prescaler wraps to 0 and `restante` decrements.
  - When a tick occurs with `restante`=1: `restante`=0, `bomba`=0, `ocupado`=0, `fim_bomba` pulses, go to IDLE.
  - Else if `pausa`=1: go to PAUSADO, `bomba`=0, prescaler frozen at its current value, pause counter cleared.
- **PAUSADO**:
  - The pause counter increments each cycle.
  - If `pausa`=0: return to BOMBEANDO, `bomba`=1, prescaler resumes from its frozen value.
  - If the pause counter reaches PAUSA_MAX_CYCLES-1 while `pausa`=1: pulse `erro`, `codigo_erro`=10, go to IDLE, `bomba`=0, `restante` keeps its last value.
- Priority within a cycle: reset > `aborta` > pause timeout > dose completion > `pausa` transition.
- `aborta`=1 in BOMBEANDO or PAUSADO: go to IDLE, `bomba`=0, pulse `erro`, `codigo_erro`=11, `restante` keeps its value. In IDLE, `aborta` blocks start and does nothing else.
- `liga_bomba` while `ocupado`=1 is ignored; there is no queueing. A level held through completion re-starts on the first IDLE cycle.
- Changes to `modo` and `dose_custom` after start have no effect.
- Counter widths:
  - Prescaler: clog2(TICK_CYCLES).
  - Pause counter: clog2(PAUSA_MAX_CYCLES).
  - `restante` never underflows.

## Timing
- Start sampled at edge k → `bomba`=1 visible after edge k.
- With no pause, `bomba` is high for exactly dose × TICK_CYCLES cycles. It falls at edge k + dose×TICK_CYCLES, the same edge `fim_bomba` rises; the pulse lasts 1 cycle.
- Pauses add exactly their duration; total pump-on cycles remain dose × TICK_CYCLES.
- `pausa` sampled at edge p → `bomba`=0 after edge p. Release sampled at edge r → `bomba`=1 after edge r.
- Pause timeout: `erro` asserts after PAUSA_MAX_CYCLES cycles spent in PAUSADO.
- Earliest next start: the cycle after `fim_bomba` (IDLE lasts ≥1 cycle).

## Test plan
Bench parameters: TICK_CYCLES=4, DOSE_PEQUENO=3, DOSE_GRANDE=5, PAUSA_MAX_CYCLES=10.

1. Reset, then `modo`=01 with a 1-cycle `liga_bomba` → `bomba` high for exactly 12 cycles. `restante` steps 3→2→1→0 every 4 cycles. `fim_bomba` pulses once as `bomba` falls; `erro`=0.
2. `modo`=11, `dose_custom`=2, then `pausa` high for 6 cycles starting 5 cycles into the dose → `bomba` on 5, off 6, on 3 cycles (8 on total). `fim_bomba` pulses once.
3. `modo`=10, then `pausa` held for 10 cycles → `erro` pulse, `codigo_erro`=10, `bomba`=0, `ocupado`=0, `restante` unchanged (nonzero).
4. `modo`=00, start → `erro` pulse, `codigo_erro`=01, `bomba` stays 0. Repeat with `modo`=11 and `dose_custom`=0 → same response.
5. `modo`=10, `aborta` after 7 cycles → `bomba`=0 next edge, `codigo_erro`=11, `restante`=4. A second `liga_bomba` mid-dose in a fresh run is ignored, and `restante` is not reloaded.
6. `reset`=0 for 1 cycle mid-dose and mid-pause → all outputs 0 and IDLE. A new start afterwards delivers a full 12-cycle small dose.

Source files
------------

// File: rtl/controle_bomba_dosagem.sv
// Pump dosing controller: runs the pump for an exact number of dose ticks,
// chosen from two presets or a runtime custom value, with pause and abort.
//
// Parameters:
//   TICK_CYCLES      clock cycles per dose tick
//   TICK_W           width of dose / remaining-tick values
//   DOSE_PEQUENO     ticks for the small dose
//   DOSE_GRANDE      ticks for the large dose
//   PAUSA_MAX_CYCLES maximum continuous cycles spent paused
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   modo         01 small, 10 large, 11 custom, 00 invalid (sampled at start)
//   dose_custom  custom dose in ticks for modo 11 (sampled at start)
//   liga_bomba   start request, accepted only in IDLE
//   pausa        hold the pump off and freeze dose timing
//   aborta       terminate an active dose
//   bomba        pump enable
//   ocupado      high while a dose is active (pumping or paused)
//   fim_bomba    one-cycle pulse on successful completion
//   erro         one-cycle pulse on rejected start or failed dose
//   codigo_erro  01 invalid start, 10 pause timeout, 11 aborted
//   restante     ticks of dose remaining
module controle_bomba_dosagem #(
    parameter int TICK_CYCLES      = 500000,
    parameter int TICK_W           = 16,
    parameter int DOSE_PEQUENO     = 625,
    parameter int DOSE_GRANDE      = 1250,
    parameter int PAUSA_MAX_CYCLES = 1500000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        modo,
    input  logic [TICK_W-1:0] dose_custom,
    input  logic              liga_bomba,
    input  logic              pausa,
    input  logic              aborta,
    output logic              bomba,
    output logic              ocupado,
    output logic              fim_bomba,
    output logic              erro,
    output logic [1:0]        codigo_erro,
    output logic [TICK_W-1:0] restante
);

    localparam int PRE_W =
        (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PAU_W =
        (PAUSA_MAX_CYCLES > 1) ? $clog2(PAUSA_MAX_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST =
        PRE_W'(TICK_CYCLES - 1);
    localparam logic [PAU_W-1:0] PAU_LAST =
        PAU_W'(PAUSA_MAX_CYCLES - 1);

    localparam logic [TICK_W-1:0] DOSE_P = TICK_W'(DOSE_PEQUENO);
    localparam logic [TICK_W-1:0] DOSE_G = TICK_W'(DOSE_GRANDE);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BOMBEANDO,
        PAUSADO
    } estado_t;

    estado_t           estado;
    estado_t           estado_nxt;
    logic [PRE_W-1:0]  prescaler;
    logic [PRE_W-1:0]  prescaler_nxt;
    logic [PAU_W-1:0]  cnt_pausa;
    logic [PAU_W-1:0]  cnt_pausa_nxt;
    logic [TICK_W-1:0] restante_nxt;
    logic              bomba_nxt;
    logic              ocupado_nxt;
    logic              fim_nxt;
    logic              erro_nxt;
    logic [1:0]        codigo_nxt;

    logic [TICK_W-1:0] dose_sel;
    logic              modo_ok;
    logic              tick;
    logic [PRE_W-1:0]  prescaler_inc;

    // Dose selection from the mode inputs; only used on an IDLE start.
    always_comb begin
        dose_sel = '0;
        modo_ok  = 1'b1;
        case (modo)
            2'b01:   dose_sel = DOSE_P;
            2'b10:   dose_sel = DOSE_G;
            2'b11:   dose_sel = dose_custom;
            default: modo_ok  = 1'b0;
        endcase
    end

    assign tick = (prescaler == PRE_LAST);

    assign prescaler_inc =
        tick ? '0 : prescaler + PRE_W'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= IDLE;
            prescaler   <= '0;
            cnt_pausa   <= '0;
            restante    <= '0;
            bomba       <= 1'b0;
            ocupado     <= 1'b0;
            fim_bomba   <= 1'b0;
            erro        <= 1'b0;
            codigo_erro <= ERR_NONE;
        end else begin
            estado      <= estado_nxt;
            prescaler   <= prescaler_nxt;
            cnt_pausa   <= cnt_pausa_nxt;
            restante    <= restante_nxt;
            bomba       <= bomba_nxt;
            ocupado     <= ocupado_nxt;
            fim_bomba   <= fim_nxt;
            erro        <= erro_nxt;
            codigo_erro <= codigo_nxt;
        end
    end

    always_comb begin
        estado_nxt    = estado;
        prescaler_nxt = prescaler;
        cnt_pausa_nxt = cnt_pausa;
        restante_nxt  = restante;
        bomba_nxt     = bomba;
        ocupado_nxt   = ocupado;
        fim_nxt       = 1'b0;
        erro_nxt      = 1'b0;
        codigo_nxt    = codigo_erro;

        unique case (estado)
            IDLE: begin
                bomba_nxt   = 1'b0;
                ocupado_nxt = 1'b0;
                if (liga_bomba && !aborta) begin
                    if (!modo_ok || dose_sel == '0) begin
                        erro_nxt   = 1'b1;
                        codigo_nxt = ERR_INVALID;
                    end else begin
                        estado_nxt    = BOMBEANDO;
                        restante_nxt  = dose_sel;
                        prescaler_nxt = '0;
                        codigo_nxt    = ERR_NONE;
                        bomba_nxt     = 1'b1;
                        ocupado_nxt   = 1'b1;
                    end
                end
            end

            BOMBEANDO: begin
                if (aborta) begin
                    estado_nxt  = IDLE;
                    bomba_nxt   = 1'b0;
                    ocupado_nxt = 1'b0;
                    erro_nxt    = 1'b1;
                    codigo_nxt  = ERR_ABORT;
                end else begin
                    // The cycle that just elapsed was a pump cycle, so
                    // it is counted even when a pause starts on it;
                    // this keeps total pump-on time equal to the dose.
                    prescaler_nxt = prescaler_inc;
                    if (tick && restante != '0) begin
                        restante_nxt = restante - TICK_W'(1);
                    end
                    if (tick && restante == TICK_W'(1)) begin
                        estado_nxt  = IDLE;
                        bomba_nxt   = 1'b0;
                        ocupado_nxt = 1'b0;
                        fim_nxt     = 1'b1;
                    end else if (pausa) begin
                        estado_nxt    = PAUSADO;
                        bomba_nxt     = 1'b0;
                        cnt_pausa_nxt = '0;
                    end
                end
            end

            PAUSADO: begin
                if (aborta) begin
                    estado_nxt  = IDLE;
                    bomba_nxt   = 1'b0;
                    ocupado_nxt = 1'b0;
                    erro_nxt    = 1'b1;
                    codigo_nxt  = ERR_ABORT;
                end else if (pausa && cnt_pausa == PAU_LAST) begin
                    estado_nxt  = IDLE;
                    bomba_nxt   = 1'b0;
                    ocupado_nxt = 1'b0;
                    erro_nxt    = 1'b1;
                    codigo_nxt  = ERR_TIMEOUT;
                end else if (!pausa) begin
                    estado_nxt = BOMBEANDO;
                    bomba_nxt  = 1'b1;
                end else begin
                    cnt_pausa_nxt = cnt_pausa + PAU_W'(1);
                end
            end

            default: begin
                estado_nxt  = IDLE;
                bomba_nxt   = 1'b0;
                ocupado_nxt = 1'b0;
            end
        endcase
    end

endmodule
